blackbox_sweeper: RTL and testbench

Sequencer that characterises the 3-input combinational `blackbox` unit (inputs `x`, `b`, `d`; output `z`) by sweeping all 8 input vectors and recording `z` for each one. It lets the lab harness self-check a `blackbox` instance, or a candidate re-implementation of it, in-circuit. The block drives the unit's inputs, waits a programmable settle time per vector, samples `z`, and assembles an 8-bit truth table. It then compares the table against an expected constant and reports pass/fail and the first failing vector.

---
 rtl/blackbox_sweeper.sv | 152 +++++++++++++++
 tb/tb_blackbox_sweeper.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackbox_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : blackbox_sweeper
// Description : Sweeps all 8 input vectors {x,b,d} of a 3-input combinational
//               unit. Each vector is held for SETTLE cycles and then z is
//               sampled. The sweep builds an 8-bit truth table, which is
//               compared against EXPECTED to give pass/fail and the lowest
//               failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module blackbox_sweeper #(
  parameter int          SETTLE   = 1,     // legal range 1..255
  parameter logic [7:0]  EXPECTED = 8'h31
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  output logic       x,
  output logic       b,
  output logic       d,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic       pass,
  output logic [2:0] first_bad
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Compare against SETTLE-1 so the 8-bit counter never has to reach SETTLE.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] truth_q, truth_d;
  logic       pass_q, pass_d;
  logic [2:0] first_bad_q, first_bad_d;

  // Table with the current vector's z merged in. It is used both for the
  // normal capture and for the final pass/first_bad verdict.
  logic [7:0] w_truth_cap;
  logic [7:0] w_diff;

  // Lowest set bit of v; 0 when v is all zeros.
  function automatic logic [2:0] f_lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next-state and datapath decode for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    truth_d     = truth_q;
    pass_d      = pass_q;
    first_bad_d = first_bad_q;
    w_truth_cap = truth_q;
    w_truth_cap[idx_q] = z;
    w_diff      = w_truth_cap ^ EXPECTED;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_SETTLE;
          idx_d       = 3'd0;
          cnt_d       = 8'd0;
          truth_d     = 8'd0;
          pass_d      = 1'b0;
          first_bad_d = 3'd0;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          // Abort wins over the capture; the partial table is kept as-is.
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end else begin
          truth_d = w_truth_cap;
          if (idx_q == 3'd7) begin
            // The verdict is registered together with the final bit so it
            // is already valid while done is high.
            state_d     = ST_DONE;
            idx_d       = 3'd0;
            pass_d      = (w_truth_cap == EXPECTED);
            first_bad_d = f_lowest_set(w_diff);
          end else begin
            state_d = ST_SETTLE;
            idx_d   = idx_q + 3'd1;
            cnt_d   = 8'd0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= 8'd0;
      truth_q     <= 8'd0;
      pass_q      <= 1'b0;
      first_bad_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      truth_q     <= truth_d;
      pass_q      <= pass_d;
      first_bad_q <= first_bad_d;
    end
  end

  assign {x, b, d}  = idx_q;
  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done       = (state_q == ST_DONE);
  assign truth      = truth_q;
  assign pass       = pass_q;
  assign first_bad  = first_bad_q;

endmodule
`default_nettype wire

// File: tb/tb_blackbox_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_blackbox_sweeper
// Description : Scoreboard bench for blackbox_sweeper. Two instances are
//               used, one with SETTLE=1 and one with SETTLE=3. Each unit
//               under test is a lookup table, so it can act as the golden
//               unit, as stuck-at-0 or stuck-at-1, or as a random function.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blackbox_sweeper;

  typedef struct {
    int         unit;
    int         c0;      // cycle count right after the accepting edge
    logic [7:0] truth;
    logic       pass;
    logic [2:0] fb;
  } exp_t;

  localparam logic [7:0] GOLDEN = 8'h31;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] start_u, abort_u, x_u, b_u, d_u, z_u, busy_u, done_u, pass_u;
  logic [7:0] truth_u [2];
  logic [2:0] fb_u    [2];
  logic [7:0] tbl     [2];

  exp_t sbq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   m_k, m_s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    blackbox_sweeper #(.SETTLE(g == 0 ? 1 : 3), .EXPECTED(GOLDEN)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start_u[g]),
      .abort    (abort_u[g]),
      .x        (x_u[g]),
      .b        (b_u[g]),
      .d        (d_u[g]),
      .z        (z_u[g]),
      .busy     (busy_u[g]),
      .done     (done_u[g]),
      .truth    (truth_u[g]),
      .pass     (pass_u[g]),
      .first_bad(fb_u[g])
    );
    assign z_u[g] = tbl[g][{x_u[g], b_u[g], d_u[g]}];
  end

  function automatic int settle_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result of a full sweep over the lookup table t.
  function automatic exp_t model(input int u, input int c0, input logic [7:0] t);
    exp_t       e;
    logic [7:0] diff;
    bit         found;
    e.unit  = u;
    e.c0    = c0;
    e.truth = t;
    e.pass  = (t == GOLDEN);
    e.fb    = 3'd0;
    diff    = t ^ GOLDEN;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && diff[i]) begin
        e.fb  = 3'(i);
        found = 1'b1;
      end
    end
    return e;
  endfunction

  // Monitor. While a sweep is expected, it checks the busy window, the
  // vector being driven, the done cycle and the final results.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      for (int u = 0; u < 2; u++) begin
        if (sbq.size() > 0 && sbq[0].unit == u) begin
          m_s = settle_of(u);
          m_k = cyc - sbq[0].c0;
          if (m_k < 0) begin
            chk("gap_done", int'(done_u[u]), 0);
          end else if (m_k < 8 * (m_s + 1)) begin
            chk("busy", int'(busy_u[u]), 1);
            chk("early_done", int'(done_u[u]), 0);
            chk("vector", int'({x_u[u], b_u[u], d_u[u]}), m_k / (m_s + 1));
          end else begin
            chk("done", int'(done_u[u]), 1);
            chk("busy_at_done", int'(busy_u[u]), 0);
            chk("truth", int'(truth_u[u]), int'(sbq[0].truth));
            chk("pass", int'(pass_u[u]), int'(sbq[0].pass));
            chk("first_bad", int'(fb_u[u]), int'(sbq[0].fb));
            void'(sbq.pop_front());
          end
        end else begin
          chk("spurious_done", int'(done_u[u]), 0);
        end
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic go(input int u, input logic [7:0] t);
    @(posedge clk); #1;
    tbl[u]     = t;
    start_u[u] = 1'b1;
    @(posedge clk); #1;
    start_u[u] = 1'b0;
    sbq.push_back(model(u, cyc, t));
    wait_drain();
  endtask

  task automatic chk_all_zero(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk({tag, "_busy"}, int'(busy_u[u]), 0);
      chk({tag, "_done"}, int'(done_u[u]), 0);
      chk({tag, "_truth"}, int'(truth_u[u]), 0);
      chk({tag, "_pass"}, int'(pass_u[u]), 0);
      chk({tag, "_fb"}, int'(fb_u[u]), 0);
      chk({tag, "_xbd"}, int'({x_u[u], b_u[u], d_u[u]}), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] t;
    int         c0;
    reset_n = 1'b0;
    start_u = 2'b00;
    abort_u = 2'b00;
    tbl[0]  = GOLDEN;
    tbl[1]  = GOLDEN;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); #1;
    reset_n = 1'b1;

    // Golden, stuck-at-0 and stuck-at-1 units with SETTLE=1.
    go(0, GOLDEN);
    go(0, 8'h00);
    go(0, 8'hFF);
    // Random truth tables.
    for (int i = 0; i < 6; i++) go(0, 8'($urandom));
    // SETTLE=3 instance.
    go(1, GOLDEN);
    go(1, 8'($urandom));

    // Abort five cycles into a sweep.
    @(posedge clk); #1;
    t = 8'($urandom);
    tbl[0]     = t;
    start_u[0] = 1'b1;
    @(posedge clk); #1;
    start_u[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort_u[0] = 1'b1;
    @(posedge clk); #1;
    abort_u[0] = 1'b0;
    chk("abort_busy", int'(busy_u[0]), 0);
    chk("abort_xbd", int'({x_u[0], b_u[0], d_u[0]}), 0);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_hi_bits", int'(truth_u[0] >> 2), 0);
    chk("abort_lo_bits", int'(truth_u[0][1:0]), int'(t[1:0]));
    chk("abort_pass", int'(pass_u[0]), 0);

    // A start pulse while busy is ignored.
    @(posedge clk); #1;
    t = 8'($urandom);
    tbl[0]     = t;
    start_u[0] = 1'b1;
    @(posedge clk); #1;
    start_u[0] = 1'b0;
    sbq.push_back(model(0, cyc, t));
    repeat (5) @(posedge clk);
    #1;
    start_u[0] = 1'b1;
    @(posedge clk); #1;
    start_u[0] = 1'b0;
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    chk("no_restart", int'(busy_u[0]), 0);

    // start and abort together in IDLE.
    @(posedge clk); #1;
    start_u[0] = 1'b1;
    abort_u[0] = 1'b1;
    @(posedge clk); #1;
    start_u[0] = 1'b0;
    abort_u[0] = 1'b0;
    chk("start_abort_idle", int'(busy_u[0]), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("start_abort_idle_later", int'(busy_u[0]), 0);

    // Reset pulsed in cycle 9 of a sweep.
    @(posedge clk); #1;
    tbl[0]     = GOLDEN;
    start_u[0] = 1'b1;
    @(posedge clk); #1;
    start_u[0] = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk); #1;
    reset_n = 1'b1;
    go(0, GOLDEN);

    // With start held high, the next sweep begins on the edge after done.
    @(posedge clk); #1;
    t = 8'($urandom);
    tbl[0]     = t;
    start_u[0] = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    sbq.push_back(model(0, c0, t));
    sbq.push_back(model(0, c0 + 8 * (settle_of(0) + 1) + 2, t));
    repeat (8 * (settle_of(0) + 1) + 2) @(posedge clk);
    #1;
    start_u[0] = 1'b0;
    wait_drain();
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
